// File: rtl/uart_bps_gen.sv
// UART bit-timing generator: loadable divisor, mid-bit/bit-start/oversample strobes, frame bit counter.
// All strobes appear one cycle after the qualifying edge; there is no backpressure, and cnt_start low aborts the run.
module uart_bps_gen #(
   parameter int DIV_W      = 16,
   parameter int DEF_DIV    = 5207,
   parameter int FRAME_BITS = 10,
   parameter int OS_SHIFT   = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cnt_start,
   input  logic             cfg_load,
   input  logic [DIV_W-1:0] baud_div,
   output logic             clk_bps,
   output logic             bit_start,
   output logic             os_tick,
   output logic [3:0]       bit_idx,
   output logic             frame_done,
   output logic             busy,
   output logic             cfg_err
);

   typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

   localparam logic [DIV_W-1:0] MIN_DIV   = DIV_W'(3);
   localparam logic [DIV_W-1:0] RST_DIV   = DIV_W'(DEF_DIV);
   localparam logic [3:0]       LAST_BIT  = 4'(FRAME_BITS - 1);

   state_t           state, state_nxt;
   logic [DIV_W-1:0] div_reg, div_nxt;
   logic [DIV_W-1:0] div_cnt, div_cnt_nxt;
   logic [DIV_W-1:0] os_cnt, os_cnt_nxt;
   logic [3:0]       idx_nxt;
   logic             bps_nxt, bst_nxt, os_nxt, fd_nxt, err_nxt;
   logic [DIV_W-1:0] mid, os_last, div_clamped;
   logic [DIV_W:0]   os_span;
   logic             wrap;

   assign mid         = div_reg >> 1;
   assign os_span     = ({1'b0, div_reg} + (DIV_W+1)'(1)) >> OS_SHIFT;
   // Very short bits give a zero oversample period; treat that as a tick every cycle.
   assign os_last     = (os_span == '0) ? '0 : DIV_W'(os_span - (DIV_W+1)'(1));
   assign div_clamped = (baud_div < MIN_DIV) ? MIN_DIV : baud_div;
   assign wrap        = (div_cnt == div_reg);
   assign busy        = (state == RUN);

   always_comb begin
      state_nxt   = state;
      div_nxt     = div_reg;
      div_cnt_nxt = div_cnt;
      os_cnt_nxt  = os_cnt;
      idx_nxt     = bit_idx;
      bps_nxt     = 1'b0;
      bst_nxt     = 1'b0;
      os_nxt      = 1'b0;
      fd_nxt      = 1'b0;
      err_nxt     = 1'b0;
      case (state)
         IDLE: begin
            if (cfg_load)
               div_nxt = div_clamped;
            if (cnt_start) begin
               state_nxt   = RUN;
               div_cnt_nxt = '0;
               os_cnt_nxt  = '0;
               idx_nxt     = '0;
               bst_nxt     = 1'b1;
            end
         end
         RUN: begin
            if (!cnt_start) begin
               state_nxt   = IDLE;
               div_cnt_nxt = '0;
               os_cnt_nxt  = '0;
               idx_nxt     = '0;
            end else begin
               err_nxt    = cfg_load;
               bps_nxt    = (div_cnt == mid);
               os_nxt     = (os_cnt == os_last);
               os_cnt_nxt = (wrap || os_cnt == os_last) ? '0 : os_cnt + DIV_W'(1);
               if (wrap) begin
                  div_cnt_nxt = '0;
                  if (bit_idx == LAST_BIT) begin
                     state_nxt = HOLD;
                     idx_nxt   = '0;
                     fd_nxt    = 1'b1;
                  end else begin
                     idx_nxt = bit_idx + 4'd1;
                     bst_nxt = 1'b1;
                  end
               end else begin
                  div_cnt_nxt = div_cnt + DIV_W'(1);
               end
            end
         end
         HOLD: begin
            if (cfg_load)
               div_nxt = div_clamped;
            if (!cnt_start)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         div_reg    <= RST_DIV;
         div_cnt    <= '0;
         os_cnt     <= '0;
         bit_idx    <= '0;
         clk_bps    <= 1'b0;
         bit_start  <= 1'b0;
         os_tick    <= 1'b0;
         frame_done <= 1'b0;
         cfg_err    <= 1'b0;
      end else begin
         state      <= state_nxt;
         div_reg    <= div_nxt;
         div_cnt    <= div_cnt_nxt;
         os_cnt     <= os_cnt_nxt;
         bit_idx    <= idx_nxt;
         clk_bps    <= bps_nxt;
         bit_start  <= bst_nxt;
         os_tick    <= os_nxt;
         frame_done <= fd_nxt;
         cfg_err    <= err_nxt;
      end
   end

endmodule
